ntt_stream_ctrl: RTL and testbench

Sequencing controller for the flat NTT core (`ntt_flat`, N-bit coefficients, D lanes). It does three things in order:
- accepts one coefficient per cycle over a valid/ready stream and packs them into the core's D*N-bit input bus;
- holds that bus stable for a fixed LAT-cycle settle window, then captures the core's D*N-bit output;
- streams the captured result back out one coefficient per cycle under valid/ready.

It replaces bench-driven wide-bus loading, so the core can sit behind a narrow streaming interface.

---
 rtl/ntt_stream_ctrl_if.sv | 31 +++
 rtl/ntt_stream_ctrl.sv | 106 ++++++++++
 tb/tb_ntt_stream_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_stream_ctrl_if.sv
// Stream/core bus bundle for ntt_stream_ctrl: narrow coefficient streams in and out,
// plus the wide packed buses to and from the flat NTT core.
interface ntt_stream_ctrl_if #(
  parameter int N = 17,
  parameter int D = 128
);
  logic [N-1:0]   in_data;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic [D*N-1:0] core_a;
  logic [D*N-1:0] core_b;
  logic [N-1:0]   out_data;
  logic           out_valid;
  logic           out_last;
  logic           out_ready;
  logic           busy;
  logic           err;

  // master: the environment (upstream source, core, downstream sink)
  modport master (
    output in_data, in_valid, in_last, core_b, out_ready,
    input  in_ready, core_a, out_data, out_valid, out_last, busy, err
  );

  // slave: the controller itself
  modport slave (
    input  in_data, in_valid, in_last, core_b, out_ready,
    output in_ready, core_a, out_data, out_valid, out_last, busy, err
  );
endinterface

// File: rtl/ntt_stream_ctrl.sv
// Sequencing controller for the flat NTT core: packs a streamed frame onto core_a,
// holds it for LAT cycles, captures core_b, then streams the result back out.
module ntt_stream_ctrl #(
  parameter int N   = 17,
  parameter int D   = 128,
  parameter int LAT = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  ntt_stream_ctrl_if.slave bus
);
  localparam int IW = $clog2(D);
  localparam int WW = $clog2(LAT + 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(D - 1);
  localparam logic [WW-1:0] WCNT_LAST = WW'(LAT - 1);

  typedef enum logic [1:0] {LOAD, WAIT, DRAIN} state_t;

  state_t         state, state_n;
  logic [IW-1:0]  idx;
  logic [WW-1:0]  wcnt;
  logic [D*N-1:0] core_a_q;
  logic [D*N-1:0] cap_q;
  logic           err_q;
  logic           in_ready, out_valid;
  logic           idx_last;

  assign idx_last = (idx == IDX_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_n;
  end

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned (which would infer a latch).
  always_comb begin
    state_n = state;
    unique case (state)
      LOAD:    if (bus.in_valid && idx_last)  state_n = WAIT;
      WAIT:    if (wcnt == WCNT_LAST)         state_n = DRAIN;
      DRAIN:   if (bus.out_ready && idx_last) state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  // Handshake strobes depend on registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      LOAD:    in_ready  = 1'b1;
      DRAIN:   out_valid = 1'b1;
      default: ;
    endcase
  end

  // NOTE: core_a and the capture register are wide flops, not RAM, and their reset
  // value is visible on core_a and out_data, so they are reset with everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      wcnt     <= '0;
      core_a_q <= '0;
      cap_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (bus.in_valid) begin
            core_a_q[N*idx +: N] <= bus.in_data;
            if (idx_last) begin
              idx  <= '0;
              wcnt <= '0;
              if (!bus.in_last) err_q <= 1'b1;
            end else if (bus.in_last) begin
              // Early end of frame: restart packing; stale slices get overwritten.
              idx   <= '0;
              err_q <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (wcnt == WCNT_LAST) cap_q <= bus.core_b;
        end
        DRAIN: begin
          if (bus.out_ready) idx <= idx_last ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = cap_q[N*idx +: N];
  assign bus.out_last  = out_valid && idx_last;
  assign bus.core_a    = core_a_q;
  assign bus.busy      = (state != LOAD) || (idx != '0);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_ntt_stream_ctrl.sv
// Self-checking bench for ntt_stream_ctrl: frame-level reference model compared every
// cycle, plus directed ramp, backpressure, early-last, reset and back-to-back scenarios.
module tb_ntt_stream_ctrl;
  localparam int N   = 17;
  localparam int D   = 128;
  localparam int LAT = 128;
  localparam int BUDGET = 8 * D + 2 * LAT + 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ntt_stream_ctrl_if #(.N(N), .D(D)) bus ();
  ntt_stream_ctrl #(.N(N), .D(D), .LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Core stand-in: each lane returns (a + 1) xor salt; salt changes every cycle when
  // enabled, so a capture on the wrong edge yields different words.
  logic [N-1:0]   salt = '0;
  bit             salt_en = 1'b0;
  logic [D*N-1:0] core_b_v;

  function automatic logic [N-1:0] xform(input logic [N-1:0] a, input logic [N-1:0] s);
    logic [N-1:0] t;
    t = a + N'(1);
    return t ^ s;
  endfunction

  always_comb begin
    core_b_v = '0;
    for (int k = 0; k < D; k++) core_b_v[N*k +: N] = xform(bus.core_a[N*k +: N], salt);
  end
  assign bus.core_b = core_b_v;

  initial forever begin
    @(negedge clk);
    salt = salt_en ? N'($urandom) : '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, $signed(act), $signed(exp), $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit           live = 1'b0;
  int           m_cnt;            // words packed into the current frame
  int           m_wait;           // cycles left before the core output is captured
  logic [N-1:0] m_core_a [D];
  logic [N-1:0] out_q [$];        // captured words still to be emitted
  bit           m_err;

  function automatic bit exp_in_ready();
    return (m_wait == 0) && (out_q.size() == 0);
  endfunction

  function automatic int first_bad_lane();
    for (int k = 0; k < D; k++)
      if (bus.core_a[N*k +: N] !== m_core_a[k]) return k;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      live   = 1'b1;
      m_cnt  = 0;
      m_wait = 0;
      m_err  = 1'b0;
      out_q.delete();
      for (int k = 0; k < D; k++) m_core_a[k] = '0;
    end else if (live) begin
      if (exp_in_ready() && bus.in_valid) begin
        m_core_a[m_cnt] = bus.in_data;
        if (m_cnt == D - 1) begin
          if (!bus.in_last) m_err = 1'b1;
          m_cnt  = 0;
          m_wait = LAT;
        end else if (bus.in_last) begin
          m_err = 1'b1;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0)
          for (int k = 0; k < D; k++) out_q.push_back(xform(m_core_a[k], salt));
      end else if (out_q.size() != 0 && bus.out_ready) begin
        void'(out_q.pop_front());
      end
    end
  end

  // Compare process: every cycle once the model has seen reset.
  initial forever begin
    @(negedge clk);
    if (live) begin
      check("in_ready", 32'(bus.in_ready), 32'(exp_in_ready()));
      check("out_valid", 32'(bus.out_valid), 32'(out_q.size() != 0));
      check("out_last", 32'(bus.out_last), 32'(out_q.size() == 1));
      if (out_q.size() != 0) check("out_data", 32'(bus.out_data), 32'(out_q[0]));
      check("busy", 32'(bus.busy), 32'(!exp_in_ready() || m_cnt != 0));
      check("err", 32'(bus.err), 32'(m_err));
      check("core_a first bad lane", first_bad_lane(), -1);
    end
  end

  // ---------------- stimulus ----------------
  logic [N-1:0] fr [2][D];
  logic [N-1:0] got_q [$];
  int           dr_first, dr_last, dr_lastpos, dr_nlast;

  // Called just after a negedge; returns once the word has been taken.
  task automatic send_word(input logic [N-1:0] d, input logic last, output int edge_no);
    int n = 0;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) check("in_ready wait timeout", 32'(bus.in_ready), 1);
    edge_no = cyc + 1;
    @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input int nwords, input int last_at,
                            input bit gaps, output int first_edge);
    int e;
    first_edge = 0;
    for (int i = 0; i < nwords; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = N'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      send_word(fr[sel][i], i == last_at, e);
      if (i == 0) first_edge = e;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // mode 0: out_ready=1; mode 1: 1,0,0,1 repeating; mode 2: random.
  task automatic drain(input int mode, input int nwords);
    int p = 0, n = 0;
    got_q.delete();
    dr_lastpos = -1;
    dr_nlast   = 0;
    while (got_q.size() < nwords && n < BUDGET) begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (p % 4 == 0) || (p % 4 == 3);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (bus.out_valid === 1'b1) begin
        p++;
        if (bus.out_ready) begin
          if (got_q.size() == 0) dr_first = cyc + 1;
          if (bus.out_last) begin
            dr_nlast++;
            dr_lastpos = got_q.size();
          end
          got_q.push_back(bus.out_data);
          dr_last = cyc + 1;
        end
      end
      @(negedge clk);
      n++;
    end
    bus.out_ready = 1'b0;
    if (got_q.size() < nwords) check("drain word count (timeout)", got_q.size(), nwords);
  endtask

  task automatic check_frame(input string name, input int sel);
    int bad = 0;
    for (int i = 0; i < D; i++)
      if (i >= got_q.size() || got_q[i] !== xform(fr[sel][i], '0)) bad++;
    check({name, " words wrong"}, bad, 0);
    check({name, " out_last count"}, dr_nlast, 1);
    check({name, " out_last position"}, dr_lastpos, D - 1);
  endtask

  initial begin
    int e0, fa, fb, n, bad, r, cut;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("reset in_ready", 32'(bus.in_ready), 1);
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset busy", 32'(bus.busy), 0);
    check("reset err", 32'(bus.err), 0);
    check("reset core_a nonzero", 32'(|bus.core_a), 0);

    // Ramp load and loopback at full rate
    for (int k = 0; k < D; k++) fr[0][k] = N'(k);
    bus.out_ready = 1'b1;
    send_frame(0, D, D - 1, 1'b0, fa);
    bad = 0;
    for (int k = 0; k < D; k++) if (bus.core_a[N*k +: N] !== N'(k)) bad++;
    check("ramp core_a lanes wrong", bad, 0);
    check("ramp in_ready in WAIT", 32'(bus.in_ready), 0);
    check("ramp busy in WAIT", 32'(bus.busy), 1);
    check("ramp err", 32'(bus.err), 0);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("ramp cycles from E0 to out_valid", n, LAT);
    drain(0, D);
    for (int i = 0; i < D; i += 37) check("ramp out word", 32'(got_q[i]), i + 1);
    check("ramp last word", 32'(got_q[D-1]), D);
    check_frame("ramp", 0);
    check("ramp drain length", dr_last - dr_first, D - 1);
    check("ramp in_ready after drain", 32'(bus.in_ready), 1);
    check("ramp busy after drain", 32'(bus.busy), 0);

    // Early last on the 5th word, then a good frame drained with backpressure
    for (int k = 0; k < D; k++) fr[0][k] = N'($urandom);
    send_frame(0, 5, 4, 1'b0, fa);
    check("early-last err", 32'(bus.err), 1);
    check("early-last busy (idx back to 0)", 32'(bus.busy), 0);
    for (int k = 0; k < D; k++) fr[0][k] = N'($urandom);
    send_frame(0, D, D - 1, 1'b1, fa);
    drain(1, D);
    check_frame("backpressure", 0);
    check("err stays sticky", 32'(bus.err), 1);

    // Reset in the middle of WAIT, at wcnt=40
    send_frame(0, D, D - 1, 1'b0, fa);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midwait reset in_ready", 32'(bus.in_ready), 1);
    check("midwait reset out_valid", 32'(bus.out_valid), 0);
    check("midwait reset err", 32'(bus.err), 0);
    check("midwait reset core_a nonzero", 32'(|bus.core_a), 0);
    rst_n = 1'b1;

    // Back-to-back: B presented with in_valid high while A waits and drains
    for (int k = 0; k < D; k++) begin
      fr[0][k] = N'($urandom);
      fr[1][k] = N'($urandom);
    end
    send_frame(0, D, D - 1, 1'b0, fa);
    fork
      drain(0, D);
      send_frame(1, D, D - 1, 1'b0, fb);
    join
    check_frame("frame A", 0);
    check("B first accept edge minus A last handshake", fb - dr_last, 1);
    drain(2, D);
    check_frame("frame B", 1);

    // Randomized frames: gaps, random backpressure, per-cycle salt on the core
    salt_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < D; k++) fr[0][k] = N'($urandom);
      r = $urandom_range(0, 3);
      if (r == 0) begin
        cut = $urandom_range(0, D - 2);
        send_frame(0, cut + 1, cut, 1'b1, fa);
      end else begin
        send_frame(0, D, (r == 1) ? -1 : D - 1, 1'b1, fa);
        drain(2, D);
        check("random frame out_last count", dr_nlast, 1);
      end
    end
    salt_en = 1'b0;

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
